// File: rtl/dsp_data_mem_bank.sv
// dsp_data_mem_bank
//   Data memory bank II responder. The DSP side reads with one cycle of registered
//   latency and writes directly. A host stream port (valid/ready) fills the bank as a
//   circular sample buffer through a small FIFO. That FIFO drains only in cycles where
//   the DSP is not writing.
//
//   Optional build macro: DSP_MEM_BYPASS_EN
//     defined   - a write to the address being read in the same cycle is forwarded
//                 into dsp_read_data.
//     undefined - a same-address read returns the pre-write content.

`ifndef REG_WORD_LEN
`define REG_WORD_LEN 16
`endif

`ifndef SRAM_ADDR_LEN
`define SRAM_ADDR_LEN 6
`endif

module dsp_data_mem_bank #(
  parameter int DATA_W     = `REG_WORD_LEN,
  parameter int ADDR_W     = `SRAM_ADDR_LEN,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_W-1:0]                dsp_read_addr,
  output logic [DATA_W-1:0]                dsp_read_data,
  input  logic [ADDR_W-1:0]                dsp_write_addr,
  input  logic [DATA_W-1:0]                dsp_write_data,
  input  logic                             dsp_write_en,
  input  logic                             host_valid,
  input  logic [DATA_W-1:0]                host_data,
  output logic                             host_ready,
  input  logic                             host_clr,
  output logic [ADDR_W-1:0]                host_ptr,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [LVL_W-1:0]  LVL_ZERO  = {LVL_W{1'b0}};
  localparam logic [LVL_W-1:0]  LVL_ONE   = LVL_W'(1);
  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);
  localparam logic [IDX_W-1:0]  IDX_ZERO  = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(FIFO_DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  // Storage. The word array has no reset; its contents are undefined until written.
  logic [DATA_W-1:0] r_mem  [DEPTH];
  logic [DATA_W-1:0] r_fifo [FIFO_DEPTH];

  // Registered state.
  logic [IDX_W-1:0]  r_wr_idx;
  logic [IDX_W-1:0]  r_rd_idx;
  logic [LVL_W-1:0]  r_level;
  logic              r_ready;
  logic [ADDR_W-1:0] r_host_ptr;
  logic [DATA_W-1:0] r_rd_data;

  // Combinational helpers.
  logic              w_push;
  logic              w_pop;
  logic [IDX_W-1:0]  w_wr_idx_inc;
  logic [IDX_W-1:0]  w_rd_idx_inc;
  logic [LVL_W-1:0]  w_level_nxt;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic [DATA_W-1:0] w_rd_word;

  // Handshake qualification. A flush wins over both push and pop. Pop looks only at the
  // registered level, so a word pushed into an empty FIFO waits at least one edge.
  always_comb begin
    w_push = 1'b0;
    w_pop  = 1'b0;
    if (host_clr) begin
      w_push = 1'b0;
      w_pop  = 1'b0;
    end else begin
      w_push = host_valid & r_ready;
      w_pop  = (r_level != LVL_ZERO) & ~dsp_write_en;
    end
  end

  // Circular FIFO index increment for any depth, not only powers of two.
  always_comb begin
    w_wr_idx_inc = r_wr_idx + IDX_ONE;
    w_rd_idx_inc = r_rd_idx + IDX_ONE;
    if (r_wr_idx == IDX_LAST) begin
      w_wr_idx_inc = IDX_ZERO;
    end else begin
      w_wr_idx_inc = r_wr_idx + IDX_ONE;
    end
    if (r_rd_idx == IDX_LAST) begin
      w_rd_idx_inc = IDX_ZERO;
    end else begin
      w_rd_idx_inc = r_rd_idx + IDX_ONE;
    end
  end

  // Next FIFO occupancy. A simultaneous push and pop leave the level unchanged.
  always_comb begin
    w_level_nxt = r_level;
    if (host_clr) begin
      w_level_nxt = LVL_ZERO;
    end else if (w_push && !w_pop) begin
      w_level_nxt = r_level + LVL_ONE;
    end else if (!w_push && w_pop) begin
      w_level_nxt = r_level - LVL_ONE;
    end else begin
      w_level_nxt = r_level;
    end
  end

  // Single array write port. The DSP has priority, and the host drains only when the DSP is idle.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = ADDR_ZERO;
    w_mem_wdata = DATA_ZERO;
    if (dsp_write_en) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = dsp_write_addr;
      w_mem_wdata = dsp_write_data;
    end else if (w_pop) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = r_host_ptr;
      w_mem_wdata = r_fifo[r_rd_idx];
    end else begin
      w_mem_we    = 1'b0;
      w_mem_addr  = ADDR_ZERO;
      w_mem_wdata = DATA_ZERO;
    end
  end

  // Read word selection, with optional forwarding of a same-cycle write.
  always_comb begin
    w_rd_word = r_mem[dsp_read_addr];
`ifdef DSP_MEM_BYPASS_EN
    if (w_mem_we && (w_mem_addr == dsp_read_addr)) begin
      w_rd_word = w_mem_wdata;
    end else begin
      w_rd_word = r_mem[dsp_read_addr];
    end
`else
    w_rd_word = r_mem[dsp_read_addr];
`endif
  end

  // Commit the selected write into the word array.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  // Capture the accepted host word at the FIFO tail.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_idx] <= host_data;
    end
  end

  // FIFO pointers, occupancy and registered ready. Ready is derived from the next level, so
  // it never depends combinationally on host_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_idx <= IDX_ZERO;
      r_rd_idx <= IDX_ZERO;
      r_level  <= LVL_ZERO;
      r_ready  <= 1'b1;
    end else if (host_clr) begin
      r_wr_idx <= IDX_ZERO;
      r_rd_idx <= IDX_ZERO;
      r_level  <= LVL_ZERO;
      r_ready  <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_idx <= w_wr_idx_inc;
      end
      if (w_pop) begin
        r_rd_idx <= w_rd_idx_inc;
      end
      r_level <= w_level_nxt;
      r_ready <= (w_level_nxt != LVL_FULL);
    end
  end

  // Host commit pointer. It advances on each drain and wraps naturally at DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_host_ptr <= ADDR_ZERO;
    end else if (host_clr) begin
      r_host_ptr <= ADDR_ZERO;
    end else if (w_pop) begin
      r_host_ptr <= r_host_ptr + ADDR_ONE;
    end
  end

  // Registered read data with one cycle of latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_data <= DATA_ZERO;
    end else begin
      r_rd_data <= w_rd_word;
    end
  end

  assign dsp_read_data = r_rd_data;
  assign host_ready    = r_ready;
  assign host_ptr      = r_host_ptr;
  assign fifo_level    = r_level;

endmodule

// File: tb/tb_dsp_data_mem_bank.sv
// Self-checking bench for dsp_data_mem_bank. Expected read data comes from a bench-side
// memory model. Each value is pushed onto a scoreboard queue when its read is issued and
// popped when the registered output appears.

`timescale 1ns/1ps

module tb_dsp_data_mem_bank;

  localparam int DW = 16;
  localparam int AW = 6;
  localparam int FD = 4;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] dsp_read_addr = '0;
  logic [DW-1:0] dsp_read_data;
  logic [AW-1:0] dsp_write_addr = '0;
  logic [DW-1:0] dsp_write_data = '0;
  logic          dsp_write_en = 1'b0;
  logic          host_valid = 1'b0;
  logic [DW-1:0] host_data = '0;
  logic          host_ready;
  logic          host_clr = 1'b0;
  logic [AW-1:0] host_ptr;
  logic [2:0]    fifo_level;

  int n_cmp = 0;
  int n_fail = 0;

  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] sb [$];

  dsp_data_mem_bank #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(FD)) dut (
    .clk            (clk),
    .rst            (rst),
    .dsp_read_addr  (dsp_read_addr),
    .dsp_read_data  (dsp_read_data),
    .dsp_write_addr (dsp_write_addr),
    .dsp_write_data (dsp_write_data),
    .dsp_write_en   (dsp_write_en),
    .host_valid     (host_valid),
    .host_data      (host_data),
    .host_ready     (host_ready),
    .host_clr       (host_clr),
    .host_ptr       (host_ptr),
    .fifo_level     (fifo_level)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one host word and hold it until accepted, bounded.
  task automatic host_send(input logic [DW-1:0] d, output bit ok);
    ok = 1'b0;
    host_valid = 1'b1;
    host_data  = d;
    for (int i = 0; i < 40; i++) begin
      if (host_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    host_valid = 1'b0;
  endtask

  // Wait, bounded, for the FIFO to drain.
  task automatic wait_drain();
    for (int i = 0; i < 20; i++) begin
      if (fifo_level == 3'd0) break;
      tick();
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #3;
    n_cmp++; if (dsp_read_data !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata: got %h expected %h", dsp_read_data, 16'h0000); end
    n_cmp++; if (host_ptr !== 6'd0) begin n_fail++; $display("FAIL reset_ptr: got %0d expected 0", host_ptr); end
    n_cmp++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    n_cmp++; if (host_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", host_ready); end
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_dsp_write_read();
    logic [DW-1:0] exp;
    dsp_write_en = 1'b1; dsp_write_addr = 6'd5; dsp_write_data = 16'h1234;
    tick();
    dsp_write_en = 1'b0;
    model_mem[5] = 16'h1234;
    sb.push_back(model_mem[5]);
    dsp_read_addr = 6'd5;
    tick();
    exp = sb.pop_front();
    n_cmp++; if (dsp_read_data !== exp) begin n_fail++; $display("FAIL dsp_rw: got %h expected %h", dsp_read_data, exp); end
  endtask

  task automatic test_backpressure();
    bit ok, all_ok, acc;
    logic [DW-1:0] exp;
    all_ok = 1'b1;
    dsp_write_en = 1'b1; dsp_write_addr = 6'd40; dsp_write_data = 16'h5555;
    for (int i = 0; i < 4; i++) begin
      host_send(16'h00A0 + 16'(i), ok);
      all_ok &= ok;
    end
    n_cmp++; if (all_ok !== 1'b1) begin n_fail++; $display("FAIL bp_accept: got %b expected 1", all_ok); end
    host_valid = 1'b1; host_data = 16'h00A4;
    tick(); tick(); tick();
    n_cmp++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL bp_level: got %0d expected 4", fifo_level); end
    n_cmp++; if (host_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b expected 0", host_ready); end
    n_cmp++; if (host_ptr !== 6'd0) begin n_fail++; $display("FAIL bp_ptr_hold: got %0d expected 0", host_ptr); end
    dsp_write_en = 1'b0;
    model_mem[40] = 16'h5555;
    for (int k = 0; k < 5; k++) begin
      acc = host_valid & host_ready;
      tick();
      if (acc) host_valid = 1'b0;
      n_cmp++; if (host_ptr !== 6'(k + 1)) begin n_fail++; $display("FAIL bp_drain_ptr: got %0d expected %0d", host_ptr, k + 1); end
    end
    n_cmp++; if (host_valid !== 1'b0) begin n_fail++; $display("FAIL bp_a4_accepted: got valid %b expected 0", host_valid); end
    host_valid = 1'b0;
    n_cmp++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL bp_empty: got %0d expected 0", fifo_level); end
    for (int i = 0; i < 5; i++) model_mem[i] = 16'h00A0 + 16'(i);
    for (int i = 0; i < 6; i++) begin
      int a;
      a = (i == 5) ? 40 : i;
      sb.push_back(model_mem[a]);
      dsp_read_addr = 6'(a);
      tick();
      exp = sb.pop_front();
      n_cmp++; if (dsp_read_data !== exp) begin n_fail++; $display("FAIL bp_mem[%0d]: got %h expected %h", a, dsp_read_data, exp); end
    end
  endtask

  task automatic test_wrap();
    bit ok, all_ok;
    logic [DW-1:0] exp;
    all_ok = 1'b1;
    host_send(16'h1000, ok);
    all_ok &= ok;
    n_cmp++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL latency_level: got %0d expected 1", fifo_level); end
    n_cmp++; if (host_ptr !== 6'd5) begin n_fail++; $display("FAIL latency_ptr: got %0d expected 5", host_ptr); end
    for (int i = 1; i < 58; i++) begin
      host_send(16'h1000 + 16'(i), ok);
      all_ok &= ok;
    end
    wait_drain();
    n_cmp++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL wrap_drain1: got %0d expected 0", fifo_level); end
    n_cmp++; if (host_ptr !== 6'd63) begin n_fail++; $display("FAIL wrap_ptr_top: got %0d expected 63", host_ptr); end
    for (int i = 0; i < 58; i++) model_mem[5 + i] = 16'h1000 + 16'(i);
    host_send(16'h0011, ok); all_ok &= ok;
    host_send(16'h0022, ok); all_ok &= ok;
    wait_drain();
    n_cmp++; if (all_ok !== 1'b1) begin n_fail++; $display("FAIL wrap_accept: got %b expected 1", all_ok); end
    n_cmp++; if (host_ptr !== 6'd1) begin n_fail++; $display("FAIL wrap_ptr: got %0d expected 1", host_ptr); end
    model_mem[63] = 16'h0011;
    model_mem[0]  = 16'h0022;
    for (int i = 0; i < 4; i++) begin
      int a;
      a = (i == 0) ? 62 : (i == 1) ? 63 : (i == 2) ? 0 : 5;
      sb.push_back(model_mem[a]);
      dsp_read_addr = 6'(a);
      tick();
      exp = sb.pop_front();
      n_cmp++; if (dsp_read_data !== exp) begin n_fail++; $display("FAIL wrap_mem[%0d]: got %h expected %h", a, dsp_read_data, exp); end
    end
  endtask

  task automatic test_read_during_write();
    bit ok;
    logic [DW-1:0] exp;
    dsp_write_en = 1'b1; dsp_write_addr = 6'd9; dsp_write_data = 16'h0001;
    tick();
    model_mem[9] = 16'h0001;
    dsp_write_data = 16'hBEEF;
    dsp_read_addr = 6'd9;
`ifdef DSP_MEM_BYPASS_EN
    sb.push_back(16'hBEEF);
`else
    sb.push_back(model_mem[9]);
`endif
    tick();
    dsp_write_en = 1'b0;
    model_mem[9] = 16'hBEEF;
    exp = sb.pop_front();
    n_cmp++; if (dsp_read_data !== exp) begin n_fail++; $display("FAIL rdw_dsp: got %h expected %h", dsp_read_data, exp); end
    sb.push_back(model_mem[9]);
    tick();
    exp = sb.pop_front();
    n_cmp++; if (dsp_read_data !== exp) begin n_fail++; $display("FAIL rdw_dsp_after: got %h expected %h", dsp_read_data, exp); end
    host_send(16'h0077, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rdw_host_accept: got %b expected 1", ok); end
    dsp_read_addr = 6'd1;
`ifdef DSP_MEM_BYPASS_EN
    sb.push_back(16'h0077);
`else
    sb.push_back(model_mem[1]);
`endif
    tick();
    model_mem[1] = 16'h0077;
    exp = sb.pop_front();
    n_cmp++; if (dsp_read_data !== exp) begin n_fail++; $display("FAIL rdw_host: got %h expected %h", dsp_read_data, exp); end
    sb.push_back(model_mem[1]);
    tick();
    exp = sb.pop_front();
    n_cmp++; if (dsp_read_data !== exp) begin n_fail++; $display("FAIL rdw_host_after: got %h expected %h", dsp_read_data, exp); end
  endtask

  task automatic test_clr();
    bit ok, all_ok;
    logic [DW-1:0] exp;
    all_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      host_send(16'h2000 + 16'(i), ok);
      all_ok &= ok;
      model_mem[2 + i] = 16'h2000 + 16'(i);
    end
    wait_drain();
    n_cmp++; if (host_ptr !== 6'd6) begin n_fail++; $display("FAIL clr_setup_ptr: got %0d expected 6", host_ptr); end
    dsp_write_en = 1'b1; dsp_write_addr = 6'd50; dsp_write_data = 16'h5A5A;
    for (int i = 0; i < 3; i++) begin
      host_send(16'h3000 + 16'(i), ok);
      all_ok &= ok;
    end
    n_cmp++; if (all_ok !== 1'b1) begin n_fail++; $display("FAIL clr_accept: got %b expected 1", all_ok); end
    n_cmp++; if (fifo_level !== 3'd3) begin n_fail++; $display("FAIL clr_setup_level: got %0d expected 3", fifo_level); end
    host_valid = 1'b1; host_data = 16'h3FFF; host_clr = 1'b1;
    tick();
    host_clr = 1'b0; host_valid = 1'b0;
    n_cmp++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL clr_level: got %0d expected 0", fifo_level); end
    n_cmp++; if (host_ptr !== 6'd0) begin n_fail++; $display("FAIL clr_ptr: got %0d expected 0", host_ptr); end
    n_cmp++; if (host_ready !== 1'b1) begin n_fail++; $display("FAIL clr_ready: got %b expected 1", host_ready); end
    dsp_write_en = 1'b0;
    model_mem[50] = 16'h5A5A;
    tick(); tick(); tick();
    n_cmp++; if (host_ptr !== 6'd0) begin n_fail++; $display("FAIL clr_ptr_stays: got %0d expected 0", host_ptr); end
    n_cmp++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL clr_level_stays: got %0d expected 0", fifo_level); end
    for (int i = 0; i < 5; i++) begin
      int a;
      a = (i < 3) ? (6 + i) : (i == 3) ? 50 : 0;
      sb.push_back(model_mem[a]);
      dsp_read_addr = 6'(a);
      tick();
      exp = sb.pop_front();
      n_cmp++; if (dsp_read_data !== exp) begin n_fail++; $display("FAIL clr_mem[%0d]: got %h expected %h", a, dsp_read_data, exp); end
    end
  endtask

  task automatic test_reset_mid_drain();
    bit ok, all_ok;
    logic [DW-1:0] exp;
    all_ok = 1'b1;
    dsp_read_addr = 6'd50;
    dsp_write_en = 1'b1; dsp_write_addr = 6'd55; dsp_write_data = 16'hC3C3;
    for (int i = 0; i < 4; i++) begin
      host_send(16'h4000 + 16'(i), ok);
      all_ok &= ok;
    end
    n_cmp++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL rmd_full: got %0d expected 4", fifo_level); end
    dsp_write_en = 1'b0;
    model_mem[55] = 16'hC3C3;
    tick();
    model_mem[0] = 16'h4000;
    n_cmp++; if (fifo_level !== 3'd3) begin n_fail++; $display("FAIL rmd_level3: got %0d expected 3", fifo_level); end
    n_cmp++; if (dsp_read_data !== model_mem[50]) begin n_fail++; $display("FAIL rmd_pre_rdata: got %h expected %h", dsp_read_data, model_mem[50]); end
    rst = 1'b0;
    #1;
    n_cmp++; if (dsp_read_data !== 16'h0000) begin n_fail++; $display("FAIL rmd_rdata: got %h expected 0000", dsp_read_data); end
    n_cmp++; if (host_ptr !== 6'd0) begin n_fail++; $display("FAIL rmd_ptr: got %0d expected 0", host_ptr); end
    n_cmp++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL rmd_level: got %0d expected 0", fifo_level); end
    n_cmp++; if (host_ready !== 1'b1) begin n_fail++; $display("FAIL rmd_ready: got %b expected 1", host_ready); end
    tick(); tick();
    rst = 1'b1;
    tick(); tick();
    n_cmp++; if (host_ptr !== 6'd0) begin n_fail++; $display("FAIL rmd_ptr_after: got %0d expected 0", host_ptr); end
    n_cmp++; if (all_ok !== 1'b1) begin n_fail++; $display("FAIL rmd_accept: got %b expected 1", all_ok); end
    for (int i = 0; i < 3; i++) begin
      int a;
      a = (i == 0) ? 0 : (i == 1) ? 1 : 55;
      sb.push_back(model_mem[a]);
      dsp_read_addr = 6'(a);
      tick();
      exp = sb.pop_front();
      n_cmp++; if (dsp_read_data !== exp) begin n_fail++; $display("FAIL rmd_mem[%0d]: got %h expected %h", a, dsp_read_data, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_dsp_write_read();
    test_backpressure();
    test_wrap();
    test_read_during_write();
    test_clr();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
